// File: rtl/alu4_sched.sv
// alu4_sched: schedules two requesters onto one shared alu4 datapath.
//
// One operation is in flight at a time. A round-robin arbiter grants a
// requester in IDLE, the granted op word is registered and driven to the
// datapath, the datapath is given EXEC_CYCLES cycles to settle, the result is
// captured and presented as a valid/ready response.
//
// Parameters
//   EXEC_CYCLES  settle cycles per operation, 1..15
//   CNT_W        width of the completion counter before it saturates (1..16);
//                the default of 16 saturates done_cnt at 0xFFFF
//
// Ports
//   i_clk_       clock, rising edge
//   i_rst_       synchronous active-high reset
//   req0_valid   requester 0 has an op pending
//   req0_op      requester 0 op word (bit k -> alu4 input i_k_)
//   req0_ready   requester 0 accepted this cycle
//   req1_valid   requester 1 has an op pending
//   req1_op      requester 1 op word
//   req1_ready   requester 1 accepted this cycle
//   alu_in       registered drive to the alu4 inputs
//   alu_out      alu4 outputs zz00..zz07
//   rsp_valid    result available
//   rsp_ready    consumer accepts result
//   rsp_data     captured alu4 result
//   rsp_id       requester that issued the result
//   busy         high whenever not idle
//   done_cnt     saturating count of completed response handshakes

module alu4_sched #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        i_clk_,
  input  logic        i_rst_,
  input  logic        req0_valid,
  input  logic [13:0] req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [13:0] req1_op,
  output logic        req1_ready,
  output logic [13:0] alu_in,
  input  logic [7:0]  alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_id,
  output logic        busy,
  output logic [15:0] done_cnt
);

  localparam logic [3:0]  SettleLoad = 4'(EXEC_CYCLES);
  localparam logic [15:0] DoneMax    = 16'((32'd1 << CNT_W) - 32'd1);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic [13:0] op_q, op_d;
  logic        id_q, id_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  settle_q, settle_d;
  logic [15:0] done_q, done_d;
  logic        grant1;

  always_ff @(posedge i_clk_) begin
    if (i_rst_) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      op_q     <= '0;
      id_q     <= 1'b0;
      data_q   <= '0;
      settle_q <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      op_q     <= op_d;
      id_q     <= id_d;
      data_q   <= data_d;
      settle_q <= settle_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    op_d       = op_q;
    id_d       = id_q;
    data_d     = data_q;
    settle_d   = settle_q;
    done_d     = done_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // Requester 1 wins when it is the only one asking, or both ask and it
    // holds priority.
    grant1     = req1_valid & (~req0_valid | prio_q);

    unique case (state_q)
      StIdle: begin
        if (req0_valid || req1_valid) begin
          if (grant1) begin
            req1_ready = 1'b1;
            op_d       = req1_op;
            id_d       = 1'b1;
          end else begin
            req0_ready = 1'b1;
            op_d       = req0_op;
            id_d       = 1'b0;
          end
          prio_d   = ~grant1;
          settle_d = SettleLoad;
          state_d  = StExec;
        end
      end
      StExec: begin
        // A zero count can only arise from an illegal parameter; treat it like
        // the last settle cycle so the FSM cannot get stuck.
        if (settle_q <= 4'd1) begin
          data_d   = alu_out;
          settle_d = '0;
          state_d  = StResp;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          if (done_q != DoneMax) begin
            done_d = done_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign alu_in    = op_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != StIdle);
  assign done_cnt  = done_q;

endmodule

// File: tb/tb_alu4_sched.sv
module tb_alu4_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Stand-in combinational model of the alu4 datapath.
  function automatic logic [7:0] alu_model(input logic [13:0] x);
    return (x[7:0] + {2'b00, x[13:8]}) ^ 8'h5A;
  endfunction

  // DUT with EXEC_CYCLES=1
  logic        r0v = 1'b0, r1v = 1'b0, rspr = 1'b1;
  logic [13:0] r0op = '0, r1op = '0;
  logic        r0rdy, r1rdy, rv1, rid1, busy1;
  logic [13:0] alu_in1;
  logic [7:0]  alu_out1, rd1;
  logic [15:0] dc1;
  assign alu_out1 = alu_model(alu_in1);

  alu4_sched #(.EXEC_CYCLES(1)) d1 (
    .i_clk_(clk), .i_rst_(rst),
    .req0_valid(r0v), .req0_op(r0op), .req0_ready(r0rdy),
    .req1_valid(r1v), .req1_op(r1op), .req1_ready(r1rdy),
    .alu_in(alu_in1), .alu_out(alu_out1),
    .rsp_valid(rv1), .rsp_ready(rspr), .rsp_data(rd1), .rsp_id(rid1),
    .busy(busy1), .done_cnt(dc1)
  );

  // Narrow-counter twin, fed in lockstep with d1, for the saturation check.
  logic        s_r0rdy, s_r1rdy, s_rv, s_rid, s_busy;
  logic [13:0] s_alu_in;
  logic [7:0]  s_alu_out, s_rd;
  logic [15:0] s_dc;
  assign s_alu_out = alu_model(s_alu_in);

  alu4_sched #(.EXEC_CYCLES(1), .CNT_W(4)) ds (
    .i_clk_(clk), .i_rst_(rst),
    .req0_valid(r0v), .req0_op(r0op), .req0_ready(s_r0rdy),
    .req1_valid(r1v), .req1_op(r1op), .req1_ready(s_r1rdy),
    .alu_in(s_alu_in), .alu_out(s_alu_out),
    .rsp_valid(s_rv), .rsp_ready(rspr), .rsp_data(s_rd), .rsp_id(s_rid),
    .busy(s_busy), .done_cnt(s_dc)
  );

  // DUT with EXEC_CYCLES=4, alu_out driven directly by the bench.
  logic        v4 = 1'b0, rr4 = 1'b1;
  logic [13:0] op4 = '0;
  logic [7:0]  alu4_drv = '0;
  logic        rdy4, rdy4_1, rv4, rid4, busy4;
  logic [13:0] alu_in4;
  logic [7:0]  rd4;
  logic [15:0] dc4;

  alu4_sched #(.EXEC_CYCLES(4)) d4 (
    .i_clk_(clk), .i_rst_(rst),
    .req0_valid(v4), .req0_op(op4), .req0_ready(rdy4),
    .req1_valid(1'b0), .req1_op(14'h0), .req1_ready(rdy4_1),
    .alu_in(alu_in4), .alu_out(alu4_drv),
    .rsp_valid(rv4), .rsp_ready(rr4), .rsp_data(rd4), .rsp_id(rid4),
    .busy(busy4), .done_cnt(dc4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Ends at a negedge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [13:0] op;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 14'h2A5B, 8'hDF};
    vecs[1] = '{1'b1, 14'h3FFF, 8'h64};
    vecs[2] = '{1'b1, 14'h0001, 8'h5B};
    vecs[3] = '{1'b0, 14'h1234, 8'h1C};
    vecs[4] = '{1'b1, 14'h0000, 8'h5A};
    vecs[5] = '{1'b0, 14'h0ABC, 8'h9C};

    // Reset state
    do_reset();
    #1;
    chk("rst_alu_in", 32'(alu_in1), 32'h0);
    chk("rst_rsp_valid", 32'(rv1), 32'h0);
    chk("rst_rsp_id", 32'(rid1), 32'h0);
    chk("rst_busy", 32'(busy1), 32'h0);
    chk("rst_readys", 32'({r0rdy, r1rdy}), 32'h0);
    chk("rst_done_cnt", 32'(dc1), 32'h0);

    // Single ops, one requester at a time; the other pokes during EXEC.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (vecs[k].sel) begin r1v = 1'b1; r1op = vecs[k].op; end
      else begin r0v = 1'b1; r0op = vecs[k].op; end
      #1;
      chk("vec_ready", 32'({r1rdy, r0rdy}), vecs[k].sel ? 32'h2 : 32'h1);
      @(negedge clk);
      if (vecs[k].sel) begin r1v = 1'b0; r0v = 1'b1; r0op = 14'h2222; end
      else begin r0v = 1'b0; r1v = 1'b1; r1op = 14'h2222; end
      #1;
      chk("vec_alu_in", 32'(alu_in1), 32'(vecs[k].op));
      chk("vec_exec_busy", 32'({busy1, rv1}), 32'h2);
      chk("vec_exec_noready", 32'({r1rdy, r0rdy}), 32'h0);
      @(negedge clk);
      r0v = 1'b0;
      r1v = 1'b0;
      #1;
      chk("vec_rsp_valid", 32'(rv1), 32'h1);
      chk("vec_rsp_data", 32'(rd1), 32'(vecs[k].exp));
      chk("vec_rsp_id", 32'(rid1), 32'(vecs[k].sel));
      chk("vec_alu_in_held", 32'(alu_in1), 32'(vecs[k].op));
      @(negedge clk);
      #1;
      chk("vec_done_cnt", 32'(dc1), 32'(k + 1));
      chk("vec_idle", 32'({busy1, rv1}), 32'h0);
    end

    // Contention: both valids high out of reset, grants alternate.
    r0v = 1'b1; r0op = 14'h0001;
    r1v = 1'b1; r1op = 14'h3FFF;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_grant", 32'({r1rdy, r0rdy}), (i % 2 == 1) ? 32'h2 : 32'h1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("cont_rsp_valid", 32'(rv1), 32'h1);
      chk("cont_rsp_id", 32'(rid1), 32'(i % 2));
      chk("cont_rsp_data", 32'(rd1), (i % 2 == 1) ? 32'h64 : 32'h5B);
      chk("cont_resp_noready", 32'({r1rdy, r0rdy}), 32'h0);
      if (i == 3) begin r0v = 1'b0; r1v = 1'b0; end
      @(negedge clk);
    end
    #1;
    chk("cont_done_cnt", 32'(dc1), 32'h4);
    chk("cont_idle", 32'(busy1), 32'h0);

    // Backpressure: hold RESP for 10 cycles with both valids high.
    do_reset();
    rspr = 1'b0;
    r0v = 1'b1; r0op = 14'h0ABC;
    #1;
    chk("bp_accept", 32'({r1rdy, r0rdy}), 32'h1);
    @(negedge clk);
    r0v = 1'b0;
    @(negedge clk);
    r0v = 1'b1; r0op = 14'h1111;
    r1v = 1'b1; r1op = 14'h3333;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_hold", 32'({rv1, rid1, rd1}), 32'h29C);
      chk("bp_readys", 32'({r1rdy, r0rdy}), 32'h0);
      chk("bp_done_cnt", 32'(dc1), 32'h0);
      chk("bp_alu_in", 32'(alu_in1), 32'h0ABC);
      @(negedge clk);
    end
    rspr = 1'b1;
    #1;
    chk("bp_release_valid", 32'(rv1), 32'h1);
    @(negedge clk);
    #1;
    chk("bp_idle", 32'({busy1, rv1}), 32'h0);
    chk("bp_done_one", 32'(dc1), 32'h1);
    chk("bp_rr_grant1", 32'({r1rdy, r0rdy}), 32'h2);
    r0v = 1'b0;
    r1v = 1'b0;

    // Reset mid-EXEC: transaction dropped, prio back to req0.
    do_reset();
    r0v = 1'b1; r0op = 14'h1111;
    #1;
    chk("rm_accept", 32'({r1rdy, r0rdy}), 32'h1);
    @(negedge clk);
    r0v = 1'b0;
    rst = 1'b1;
    #1;
    chk("rm_in_exec", 32'(busy1), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    r0v = 1'b1; r0op = 14'h0001;
    r1v = 1'b1; r1op = 14'h3FFF;
    #1;
    chk("rm_no_rsp", 32'(rv1), 32'h0);
    chk("rm_busy", 32'(busy1), 32'h0);
    chk("rm_done_cnt", 32'(dc1), 32'h0);
    chk("rm_alu_in", 32'(alu_in1), 32'h0);
    chk("rm_prio_req0", 32'({r1rdy, r0rdy}), 32'h1);
    r0v = 1'b0;
    r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Latency sweep on the EXEC_CYCLES=4 instance.
    @(negedge clk);
    v4 = 1'b1; op4 = 14'h0F0F; alu4_drv = 8'h11;
    #1;
    chk("lat_accept", 32'(rdy4), 32'h1);
    @(negedge clk);
    v4 = 1'b0; alu4_drv = 8'h22;
    #1;
    chk("lat_alu_in", 32'(alu_in4), 32'h0F0F);
    chk("lat_t1", 32'(rv4), 32'h0);
    @(negedge clk);
    alu4_drv = 8'hEE;
    #1;
    chk("lat_t2", 32'(rv4), 32'h0);
    @(negedge clk);
    alu4_drv = 8'h33;
    #1;
    chk("lat_t3", 32'(rv4), 32'h0);
    @(negedge clk);
    alu4_drv = 8'hC4;
    #1;
    chk("lat_t4", 32'(rv4), 32'h0);
    @(negedge clk);
    alu4_drv = 8'h55;
    #1;
    chk("lat_t5_valid", 32'(rv4), 32'h1);
    chk("lat_t5_data", 32'(rd4), 32'hC4);
    @(negedge clk);
    #1;
    chk("lat_done", 32'({busy4, dc4}), 32'h1);

    // Saturation: 16-bit counter keeps counting, 4-bit twin sticks at 15.
    do_reset();
    r0v = 1'b1; r0op = 14'h0001; rspr = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      #1;
      chk("sat_cadence", 32'(r0rdy), 32'h1);
      if (i == 14) begin
        chk("sat_d1_14", 32'(dc1), 32'd14);
        chk("sat_ds_14", 32'(s_dc), 32'd14);
      end
      if (i == 20) begin
        chk("sat_d1_20", 32'(dc1), 32'd20);
        chk("sat_ds_20", 32'(s_dc), 32'd15);
      end
      if (i < 20) begin
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
      end
    end
    r0v = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
